// File: rtl/uart_rx_os16.sv
// UART receiver with 16x oversampling, 8N1 by default.
// The 16x sample tick comes from a clock-enable divider on clk_in, so no derived clocks exist.
// Received bytes appear on data_out with a one-cycle data_valid pulse; bad stop bits give
// a one-cycle frame_err pulse and the receiver waits for the line to return high.
module uart_rx_os16 #(
    parameter int unsigned CLKS_PER_TICK = 651,
    parameter int unsigned DATA_BITS     = 8
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] TickLast  = CW'(CLKS_PER_TICK - 1);
    localparam logic [BW-1:0] BitsTotal = BW'(DATA_BITS);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    logic                 r_sync1;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [3:0]           r_os;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;

    logic                 w_tick;
    logic [2:0]           w_state_d;
    logic [CW-1:0]        w_clk_cnt_d;
    logic [3:0]           w_os_d;
    logic [BW-1:0]        w_bit_cnt_d;
    logic [BW-1:0]        w_bit_cnt_inc;
    logic [DATA_BITS-1:0] w_shift_d;
    logic [DATA_BITS-1:0] w_data_d;
    logic                 w_valid_d;
    logic                 w_ferr_d;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

    // Next-state logic: tick divider, oversample counter, bit counter and frame FSM.
    always_comb begin
        w_tick        = (r_state != StIdle) && (r_clk_cnt == TickLast);
        w_bit_cnt_inc = r_bit_cnt + 1'b1;
        w_state_d     = r_state;
        w_clk_cnt_d   = r_clk_cnt;
        w_os_d        = r_os;
        w_bit_cnt_d   = r_bit_cnt;
        w_shift_d     = r_shift;
        w_data_d      = r_data;
        w_valid_d     = 1'b0;
        w_ferr_d      = 1'b0;

        if (r_state != StIdle) begin
            w_clk_cnt_d = w_tick ? '0 : r_clk_cnt + 1'b1;
            if (w_tick) begin
                w_os_d = r_os + 4'd1;
            end
        end

        case (r_state)
            StIdle: begin
                if (!r_rx_s) begin
                    w_state_d = StStart;
                end
            end
            StStart: begin
                // Mid start bit: a high line here means the falling edge was a glitch.
                if (w_tick && (r_os == 4'd7)) begin
                    if (!r_rx_s) begin
                        w_state_d = StData;
                        w_os_d    = 4'd0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            StData: begin
                if (w_tick && (r_os == 4'd15)) begin
                    // LSB arrives first, so shifting in at the top leaves it in bit 0.
                    w_shift_d   = {r_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_d = w_bit_cnt_inc;
                    if (w_bit_cnt_inc == BitsTotal) begin
                        w_state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (w_tick && (r_os == 4'd15)) begin
                    if (r_rx_s) begin
                        w_data_d  = r_shift;
                        w_valid_d = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_ferr_d  = 1'b1;
                        w_state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                // Wait out a held-low line so it cannot look like a new start bit.
                if (r_rx_s) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Counters always enter IDLE cleared, whichever state led there.
        if (w_state_d == StIdle) begin
            w_clk_cnt_d = '0;
            w_os_d      = 4'd0;
            w_bit_cnt_d = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_clk_cnt <= '0;
            r_os      <= 4'd0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_clk_cnt <= w_clk_cnt_d;
            r_os      <= w_os_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_data    <= w_data_d;
            r_valid   <= w_valid_d;
            r_ferr    <= w_ferr_d;
            r_busy    <= (w_state_d != StIdle);
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- UART receiver, 8N1 by default, with 16x oversampling on the system clock.
- Generates its own 16x sample tick from clk_in using an internal clock-enable divider; no derived clocks.
- Sits at the receive end of the UART link, opposite the transmitter. Feeds received bytes to downstream control logic.

Parameters:
- CLKS_PER_TICK, 651, clk_in cycles per 16x oversample tick (100 MHz / 651 ≈ 16 x 9600 baud); legal minimum 2.
- DATA_BITS, 8, data bits per frame, LSB first; legal range 5..8.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_in  input  1  serial line, idle high, asynchronous to clk_in.
- data_out  output  DATA_BITS  last correctly framed byte.
- data_valid  output  1  one-cycle pulse: data_out was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-high, and applies at any point including mid-frame. Reset values:
  - data_out = 0, data_valid = 0, frame_err = 0, busy = 0.
  - Synchronizer flops = 1.
  - State = IDLE; all counters = 0.
- rx_in passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- Tick divider: clk counter, width $clog2(CLKS_PER_TICK).
  - Held at 0 in IDLE.
  - Otherwise increments every cycle. When it equals CLKS_PER_TICK-1 it wraps to 0 and asserts tick for that cycle.
- Oversample counter os: 4 bits. Increments on tick and wraps 15 -> 0.
- Bit counter: counts received data bits, 0..DATA_BITS.
- FSM states:
  - IDLE: on the first cycle with rx_s==0, go to START. Clear the clk counter, os and the bit counter.
  - START: on tick with os==7 (mid start bit), sample rx_s.
    - If 0: go to DATA and set os=0.
    - If 1: treat as a glitch and return to IDLE. No outputs change.
  - DATA: on tick with os==15, shift rx_s into the shift register at the MSB end (LSB-first line order) and increment the bit counter. When the bit counter reaches DATA_BITS, go to STOP.
  - STOP: on tick with os==15, sample rx_s.
    - If 1: load data_out from the shift register, pulse data_valid on the next cycle, go to IDLE.
    - If 0: pulse frame_err on the next cycle, leave data_out unchanged, go to BREAK.
  - BREAK: remain until rx_s==1, then go to IDLE. This stops a held-low line from re-triggering a start.
- Timing:
  - Data bit k is sampled (8 + 16*(k+1)) * CLKS_PER_TICK cycles after the START entry cycle.
  - The stop bit is sampled at (8 + 16*(DATA_BITS+1)) * CLKS_PER_TICK cycles.
  - data_valid and frame_err are registered: they go high the cycle after the stop sample, for exactly one cycle.
- Back-to-back frames: IDLE can detect the next start edge on the cycle after returning from STOP. Tolerates ±3% baud mismatch.
- data_valid and frame_err are never high together.
- busy = (state != IDLE), registered together with the state.
- No backpressure. A new byte overwrites data_out; the consumer must capture it on the data_valid pulse.

Test Plan:
- CLKS_PER_TICK=4, send 0xA5 at 64 cycles/bit, stop=1 -> data_valid pulses once, data_out=0xA5, frame_err=0. The pulse lands 2 sync + 608 + 1 cycles after the start edge.
- Two back-to-back frames 0x00 then 0xFF with zero idle gap -> two data_valid pulses, 640 cycles apart; data_out=0x00 then 0xFF.
- Glitch: rx_in low for 12 cycles (< 8 ticks) then high -> state returns to IDLE; busy drops; data_valid and frame_err stay 0.
- Frame 0x3C with stop bit driven 0, then line held low 500 cycles, then high -> one frame_err pulse; data_out keeps its previous value; no spurious start while low. A subsequent 0x3C frame is received correctly.
- Assert rst mid-data-bit of frame 0x5A -> outputs go to reset values immediately, with no pulse. The next clean frame 0x81 gives data_out=0x81.
- Baud skew: bit period 62 and 66 cycles with CLKS_PER_TICK=4, byte 0xC3 -> data_out=0xC3 in both cases, no frame_err.
